// File: rtl/approx_mult_err_acc.sv
// approx_mult_err_acc: error statistics for an unsigned approximate WIDTHxWIDTH multiplier
//
// The block takes operand pairs plus the approximate product and recomputes the exact
// product. Over a window of 2**WINDOW_LOG2 samples it accumulates the sum of absolute
// errors, the largest absolute error and the number of erroneous samples. It then presents
// these results with a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a window (honoured in IDLE only)
//   busy              high in every state except IDLE
//   in_valid/in_ready sample handshake; x, y operands, z_approx approximate product
//   out_valid/out_ready result handshake; results held stable until accepted
//   sum_abs_err       sum of |x*y - z_approx| over the window
//   max_abs_err       largest |x*y - z_approx| in the window
//   err_count         number of samples with nonzero error
//   sum_signed_err    signed sum of (x*y - z_approx), present only when ERR_BIAS_EN is defined
//
// Configuration macro: ERR_BIAS_EN adds the signed-error accumulator and its port.
module approx_mult_err_acc #(
   parameter int WIDTH       = 8,
   parameter int WINDOW_LOG2 = 8,
   localparam int ACC_W      = 2*WIDTH+WINDOW_LOG2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       x,
   input  logic [WIDTH-1:0]       y,
   input  logic [2*WIDTH-1:0]     z_approx,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       sum_abs_err,
   output logic [2*WIDTH-1:0]     max_abs_err,
   output logic [WINDOW_LOG2:0]   err_count
`ifdef ERR_BIAS_EN
   ,
   output logic signed [ACC_W:0]  sum_signed_err
`endif
);
   localparam int PW = 2*WIDTH;
   localparam int CW = WINDOW_LOG2+1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;
   state_t state_q, state_d;
   logic [WINDOW_LOG2-1:0] smp_q;
   logic s1_v_q, s2_v_q;
   logic [WIDTH-1:0] x1_q, y1_q;
   logic [PW-1:0] z1_q, exact_d, abs_d, abs_q;
   logic [ACC_W-1:0] sum_q;
   logic [PW-1:0] max_q;
   logic [CW-1:0] cnt_q;
   logic accept, last, clr;
`ifdef ERR_BIAS_EN
   logic [PW:0] diff_d, diff_q;
   logic [ACC_W:0] ssum_q;
`endif
   assign accept = in_valid & in_ready;
   // The window closes on the acceptance of the 2**WINDOW_LOG2-th sample.
   assign last   = accept & (&smp_q);
   assign clr    = (state_q == IDLE) & start;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last) state_d = DRAIN;
         DRAIN:   if (!s1_v_q && !s2_v_q) state_d = REPORT;
         REPORT:  if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      busy      = state_q != IDLE;
      in_ready  = state_q == RUN;
      out_valid = state_q == REPORT;
   end
   // The error magnitude is taken from an ordered subtraction, so it always fits PW bits.
   always_comb begin
      exact_d = PW'(x1_q) * PW'(y1_q);
      abs_d   = exact_d >= z1_q ? exact_d - z1_q : z1_q - exact_d;
   end
`ifdef ERR_BIAS_EN
   assign diff_d = {1'b0, exact_d} - {1'b0, z1_q};
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         smp_q  <= '0;
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         x1_q   <= '0;
         y1_q   <= '0;
         z1_q   <= '0;
         abs_q  <= '0;
         sum_q  <= '0;
         max_q  <= '0;
         cnt_q  <= '0;
`ifdef ERR_BIAS_EN
         diff_q <= '0;
         ssum_q <= '0;
`endif
      end else begin
         s1_v_q <= accept;
         s2_v_q <= s1_v_q;
         if (accept) begin
            x1_q <= x;
            y1_q <= y;
            z1_q <= z_approx;
         end
         if (s1_v_q) begin
            abs_q  <= abs_d;
`ifdef ERR_BIAS_EN
            diff_q <= diff_d;
`endif
         end
         if (clr) begin
            smp_q  <= '0;
            sum_q  <= '0;
            max_q  <= '0;
            cnt_q  <= '0;
`ifdef ERR_BIAS_EN
            ssum_q <= '0;
`endif
         end else begin
            if (accept) smp_q <= smp_q + WINDOW_LOG2'(1);
            if (s2_v_q) begin
               sum_q  <= sum_q + ACC_W'(abs_q);
               max_q  <= abs_q > max_q ? abs_q : max_q;
               cnt_q  <= cnt_q + CW'(abs_q != '0);
`ifdef ERR_BIAS_EN
               ssum_q <= ssum_q + {{WINDOW_LOG2{diff_q[PW]}}, diff_q};
`endif
            end
         end
      end
   assign sum_abs_err = sum_q;
   assign max_abs_err = max_q;
   assign err_count   = cnt_q;
`ifdef ERR_BIAS_EN
   assign sum_signed_err = ssum_q;
`endif
endmodule

// File: tb/tb_approx_mult_err_acc.sv
// tb_approx_mult_err_acc: directed and randomized windows checked against an arithmetic model
module tb_approx_mult_err_acc;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0] x = '0, y = '0;
   logic [15:0] z_approx = '0;
   logic busy, in_ready, out_valid;
   logic [23:0] sum_abs_err;
   logic [15:0] max_abs_err;
   logic [8:0] err_count;
`ifdef ERR_BIAS_EN
   logic signed [24:0] sum_signed_err;
`endif
   int n_chk = 0, n_fail = 0;
   longint exp_sum, exp_max, exp_cnt, exp_ssum;

   approx_mult_err_acc dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z_approx(z_approx),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err), .err_count(err_count)
`ifdef ERR_BIAS_EN
      , .sum_signed_err(sum_signed_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_results(input string tag);
      chk({tag, ".sum"}, sum_abs_err, exp_sum);
      chk({tag, ".max"}, max_abs_err, exp_max);
      chk({tag, ".cnt"}, err_count, exp_cnt);
`ifdef ERR_BIAS_EN
      chk({tag, ".ssum"}, sum_signed_err, exp_ssum);
`endif
   endtask

   // mode 0 random, 1..3 the directed patterns
   task automatic pick(input int mode, input int idx, output logic [7:0] xv, output logic [7:0] yv, output logic [15:0] zv);
      int r;
      case (mode)
         1: begin xv = 3; yv = 5; zv = 15; end
         2: begin xv = 255; yv = 255; zv = 65024; end
         3: if (idx == 0) begin xv = 255; yv = 255; zv = 65535; end
            else begin xv = 0; yv = 0; zv = 0; end
         default: begin
            xv = 8'($urandom);
            yv = 8'($urandom);
            r = $urandom_range(0, 3);
            zv = r == 0 ? 16'(xv * yv) : r == 1 ? 16'($urandom) : 16'(xv * yv) ^ 16'($urandom_range(0, 15));
         end
      endcase
   endtask

   task automatic run_window(input int mode, input bit tog, input int start_at, input int abort_at);
      int acc, cyc, n;
      logic [7:0] xv, yv;
      logic [15:0] zv;
      logic rdy;
      longint e;
      exp_sum = 0; exp_max = 0; exp_cnt = 0; exp_ssum = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("run.busy", busy, 1);
      chk("run.in_ready", in_ready, 1);
      acc = 0; cyc = 0;
      while (acc < 256 && cyc < 3000) begin
         pick(mode, acc, xv, yv, zv);
         x = xv; y = yv; z_approx = zv;
         in_valid = tog ? ~cyc[0] : 1'b1;
         start = (cyc == start_at);
         rdy = in_ready;
         @(posedge clk); #1;
         if (in_valid && rdy) begin
            e = longint'(xv) * longint'(yv) - longint'(zv);
            exp_ssum += e;
            if (e < 0) e = -e;
            exp_sum += e;
            if (e > exp_max) exp_max = e;
            if (e != 0) exp_cnt++;
            acc++;
         end
         cyc++;
         if (abort_at > 0 && acc == abort_at) begin
            in_valid = 1'b0; start = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("abort.busy", busy, 0);
            chk("abort.in_ready", in_ready, 0);
            chk("abort.out_valid", out_valid, 0);
            chk("abort.sum", sum_abs_err, 0);
            chk("abort.max", max_abs_err, 0);
            chk("abort.cnt", err_count, 0);
            @(posedge clk); #1 rst_n = 1'b1;
            return;
         end
      end
      in_valid = 1'b0; start = 1'b0;
      chk("accepted", acc, 256);
      chk("last.in_ready", in_ready, 0);
      chk("last.out_valid", out_valid, 0);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, 3);
      chk_results("report");
      if (tog || start_at >= 0)
         for (int i = 0; i < 10; i++) begin
            start = (start_at >= 0 && i == 3);
            @(posedge clk); #1;
            chk("hold.out_valid", out_valid, 1);
            chk("hold.sum", sum_abs_err, exp_sum);
            chk("hold.max", max_abs_err, exp_max);
         end
      start = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      chk("done.busy", busy, 0);
      chk("done.out_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("idle.busy", busy, 0);
      chk_results("idle");
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", busy, 0);
      chk("rst.in_ready", in_ready, 0);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.sum", sum_abs_err, 0);
      chk("rst.max", max_abs_err, 0);
      chk("rst.cnt", err_count, 0);
      rst_n = 1'b1;
      run_window(1, 1'b0, -1, 0);
      chk("t1.sum", sum_abs_err, 0);
      chk("t1.max", max_abs_err, 0);
      chk("t1.cnt", err_count, 0);
      run_window(2, 1'b0, -1, 0);
      chk("t2.sum", sum_abs_err, 256);
      chk("t2.max", max_abs_err, 1);
      chk("t2.cnt", err_count, 256);
`ifdef ERR_BIAS_EN
      chk("t2.ssum", sum_signed_err, 256);
`endif
      run_window(3, 1'b0, -1, 0);
      chk("t3.sum", sum_abs_err, 510);
      chk("t3.max", max_abs_err, 510);
      chk("t3.cnt", err_count, 1);
`ifdef ERR_BIAS_EN
      chk("t3.ssum", sum_signed_err, -510);
`endif
      run_window(0, 1'b1, -1, 0);
      run_window(0, 1'b0, 57, 0);
      run_window(0, 1'b0, -1, 100);
      run_window(0, 1'b0, -1, 0);
      run_window(0, 1'b1, -1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
